// File: rtl/phase_accumulator_axis_if.sv
// AXI-Stream phase channel between the phase accumulator and its consumers.
interface phase_accumulator_axis_if #(
    parameter int unsigned PHASE_WIDTH = 48
);
    logic [PHASE_WIDTH-1:0] tdata;
    logic                   tvalid;
    logic                   tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/phase_accumulator_axis.sv
// DDS phase source: PHASE_WIDTH-bit accumulator streaming acc + offset over AXI-Stream.
// Frequency/offset changes take effect only at period boundaries (accumulator carry).
// Optional feature: define PHASE_GEN_PERIOD_COUNTER_EN to enable the saturating
// completed-period counter on period_count; otherwise period_count is tied to 0.
module phase_accumulator_axis #(
    parameter int unsigned PHASE_WIDTH = 48,
    parameter int unsigned CNT_WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [PHASE_WIDTH-1:0]   cfg_freq,
    input  logic [PHASE_WIDTH-1:0]   cfg_offset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     abort,
    phase_accumulator_axis_if.master m_axis_phase,
    output logic                     period_wrap,
    output logic                     done,
    output logic                     running,
    output logic [CNT_WIDTH-1:0]     period_count
);

    localparam int unsigned PW = PHASE_WIDTH;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOP_REQ = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [PW-1:0]   r_acc;
    logic [PW-1:0]   r_tdata;
    logic            r_tvalid;
    logic [PW-1:0]   r_shadow_freq;
    logic [PW-1:0]   r_shadow_off;
    logic            r_period_wrap;
    logic            r_done;
    logic            r_running;

    logic [PW-1:0]   w_acc_nxt;
    logic [PW-1:0]   w_tdata_nxt;
    logic            w_tvalid_nxt;
    logic [PW-1:0]   w_shadow_freq_nxt;
    logic [PW-1:0]   w_shadow_off_nxt;
    logic            w_wrap_nxt;
    logic            w_done_nxt;
    logic            w_cnt_clr;

    logic            w_advance;
    logic [PW:0]     w_sum;
    logic            w_carry;
    logic [PW-1:0]   w_acc_add;

    // Accumulator step; the carry out of the MSB is the only period boundary.
    assign w_advance = r_tvalid & m_axis_phase.tready;
    assign w_sum     = {1'b0, r_acc} + {1'b0, r_shadow_freq};
    assign w_carry   = w_sum[PW];
    assign w_acc_add = w_sum[PW-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort outranks stop and a concurrent carry.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_advance && w_carry && stop) begin
                    w_state_nxt = IDLE;
                end else if (stop) begin
                    w_state_nxt = STOP_REQ;
                end
            end
            STOP_REQ: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_advance && w_carry) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output/datapath next values; the wrapped sample is dropped when a stop completes.
    always_comb begin
        w_acc_nxt         = r_acc;
        w_tdata_nxt       = r_tdata;
        w_tvalid_nxt      = r_tvalid;
        w_shadow_freq_nxt = r_shadow_freq;
        w_shadow_off_nxt  = r_shadow_off;
        w_wrap_nxt        = 1'b0;
        w_done_nxt        = 1'b0;
        w_cnt_clr         = 1'b0;
        case (r_state)
            IDLE: begin
                w_acc_nxt         = '0;
                w_shadow_freq_nxt = cfg_freq;
                w_shadow_off_nxt  = cfg_offset;
                w_tvalid_nxt      = 1'b0;
                if (start) begin
                    w_tvalid_nxt = 1'b1;
                    w_tdata_nxt  = cfg_offset;
                    w_cnt_clr    = 1'b1;
                end
            end
            RUN, STOP_REQ: begin
                if (abort) begin
                    w_tvalid_nxt = 1'b0;
                    w_acc_nxt    = '0;
                end else if (w_advance) begin
                    if (w_carry) begin
                        w_wrap_nxt = 1'b1;
                        if ((r_state == STOP_REQ) || stop) begin
                            w_done_nxt   = 1'b1;
                            w_tvalid_nxt = 1'b0;
                            w_acc_nxt    = '0;
                        end else begin
                            w_acc_nxt         = w_acc_add;
                            w_shadow_freq_nxt = cfg_freq;
                            w_shadow_off_nxt  = cfg_offset;
                            w_tdata_nxt       = w_acc_add + cfg_offset;
                        end
                    end else begin
                        w_acc_nxt   = w_acc_add;
                        w_tdata_nxt = w_acc_add + r_shadow_off;
                    end
                end
            end
            default: begin
                w_tvalid_nxt = 1'b0;
                w_acc_nxt    = '0;
            end
        endcase
    end

    // Datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc         <= '0;
            r_tdata       <= '0;
            r_tvalid      <= 1'b0;
            r_shadow_freq <= '0;
            r_shadow_off  <= '0;
            r_period_wrap <= 1'b0;
            r_done        <= 1'b0;
            r_running     <= 1'b0;
        end else begin
            r_acc         <= w_acc_nxt;
            r_tdata       <= w_tdata_nxt;
            r_tvalid      <= w_tvalid_nxt;
            r_shadow_freq <= w_shadow_freq_nxt;
            r_shadow_off  <= w_shadow_off_nxt;
            r_period_wrap <= w_wrap_nxt;
            r_done        <= w_done_nxt;
            r_running     <= (w_state_nxt != IDLE);
        end
    end

`ifdef PHASE_GEN_PERIOD_COUNTER_EN
    logic [CNT_WIDTH-1:0] r_period_count;

    // Completed-period counter: cleared on start, saturating, counts each wrap pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_period_count <= '0;
        end else if (w_cnt_clr) begin
            r_period_count <= '0;
        end else if (w_wrap_nxt && (r_period_count != {CNT_WIDTH{1'b1}})) begin
            r_period_count <= r_period_count + CNT_WIDTH'(1);
        end
    end

    assign period_count = r_period_count;
`else
    logic w_cnt_clr_unused;
    assign w_cnt_clr_unused = w_cnt_clr;
    assign period_count     = '0;
`endif

    assign m_axis_phase.tdata  = r_tdata;
    assign m_axis_phase.tvalid = r_tvalid;
    assign period_wrap         = r_period_wrap;
    assign done                = r_done;
    assign running             = r_running;

endmodule

// File: tb/tb_phase_accumulator_axis.sv
// Bench for phase_accumulator_axis: directed scenarios plus random control traffic
// checked every cycle against an arithmetic model of the phase source.
module tb_phase_accumulator_axis;

    localparam int unsigned PW = 48;
    localparam int unsigned CW = 32;
    localparam logic [PW:0] MODULUS = 49'h1_0000_0000_0000;

    logic          clk;
    logic          reset;
    logic [PW-1:0] cfg_freq;
    logic [PW-1:0] cfg_offset;
    logic          start;
    logic          stop;
    logic          abort;
    logic          period_wrap;
    logic          done;
    logic          running;
    logic [CW-1:0] period_count;

    phase_accumulator_axis_if #(.PHASE_WIDTH(PW)) axis_if ();

    phase_accumulator_axis #(.PHASE_WIDTH(PW), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_freq     (cfg_freq),
        .cfg_offset   (cfg_offset),
        .start        (start),
        .stop         (stop),
        .abort        (abort),
        .m_axis_phase (axis_if),
        .period_wrap  (period_wrap),
        .done         (done),
        .running      (running),
        .period_count (period_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: generator active/stopping flags and plain modular arithmetic.
    bit            m_active;
    bit            m_stopping;
    bit            m_valid;
    logic [PW-1:0] m_data;
    logic [PW-1:0] m_acc;
    logic [PW-1:0] m_freq;
    logic [PW-1:0] m_off;
    bit            m_wrap;
    bit            m_done;
    longint        m_periods;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        logic [PW:0] sum;
        m_wrap = 1'b0;
        m_done = 1'b0;
        if (reset) begin
            m_active = 0; m_stopping = 0; m_valid = 0;
            m_data = '0; m_acc = '0; m_freq = '0; m_off = '0; m_periods = 0;
        end else if (!m_active) begin
            m_acc  = '0;
            m_freq = cfg_freq;
            m_off  = cfg_offset;
            m_valid = 0;
            if (start) begin
                m_active = 1; m_stopping = 0; m_valid = 1;
                m_data = cfg_offset;
                m_periods = 0;
            end
        end else if (abort) begin
            m_active = 0; m_valid = 0; m_acc = '0;
        end else begin
            if (m_valid && axis_if.tready) begin
                sum = {1'b0, m_acc} + {1'b0, m_freq};
                if (sum >= MODULUS) begin
                    m_wrap = 1'b1;
                    if (m_periods < 64'hFFFF_FFFF) m_periods++;
                    m_acc = PW'(sum - MODULUS);
                    if (m_stopping || stop) begin
                        m_done = 1'b1;
                        m_active = 0; m_valid = 0; m_acc = '0;
                    end else begin
                        m_freq = cfg_freq;
                        m_off  = cfg_offset;
                        m_data = PW'(({1'b0, m_acc} + {1'b0, m_off}) % MODULUS);
                    end
                end else begin
                    m_acc  = PW'(sum);
                    m_data = PW'(({1'b0, m_acc} + {1'b0, m_off}) % MODULUS);
                end
            end
            if (m_active && stop) m_stopping = 1;
        end
    endtask

    task automatic compare();
        longint exp_cnt;
`ifdef PHASE_GEN_PERIOD_COUNTER_EN
        exp_cnt = m_periods;
`else
        exp_cnt = 0;
`endif
        check("tvalid", 64'(axis_if.tvalid), 64'(m_valid));
        if (m_valid) check("tdata", 64'(axis_if.tdata), 64'(m_data));
        check("period_wrap", 64'(period_wrap), 64'(m_wrap));
        check("done", 64'(done), 64'(m_done));
        check("running", 64'(running), 64'(m_active));
        check("period_count", 64'(period_count), 64'(exp_cnt));
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        compare();
    endtask

    function automatic logic [PW-1:0] mul_pow(input int k, input int sh);
        logic [PW-1:0] v;
        v = PW'(k);
        return v << sh;
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; abort = 1'b0;
        cfg_freq = '0; cfg_offset = '0; axis_if.tready = 1'b0;
        m_active = 0; m_stopping = 0; m_valid = 0; m_data = '0; m_acc = '0;
        m_freq = '0; m_off = '0; m_wrap = 0; m_done = 0; m_periods = 0;

        // Reset state
        step(); step();
        check("rst_tvalid", 64'(axis_if.tvalid), 64'd0);
        check("rst_running", 64'(running), 64'd0);
        reset = 1'b0;

        // Basic sweep and first wrap
        cfg_freq = mul_pow(1, 45); cfg_offset = '0; axis_if.tready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        check("t1_first", 64'(axis_if.tdata), 64'd0);
        for (int k = 1; k <= 8; k++) begin
            step();
            check("t1_data", 64'(axis_if.tdata), 64'(mul_pow(k % 8, 45)));
            check("t1_wrap", 64'(period_wrap), 64'(k == 8));
        end

        // Backpressure holds the sample
        step();
        step();
        check("t2_pre", 64'(axis_if.tdata), 64'(mul_pow(1, 46)));
        axis_if.tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("t2_hold", 64'(axis_if.tdata), 64'(mul_pow(1, 46)));
            check("t2_valid", 64'(axis_if.tvalid), 64'd1);
        end
        axis_if.tready = 1'b1;
        step();
        check("t2_resume", 64'(axis_if.tdata), 64'(mul_pow(3, 45)));

        // Stop at boundary
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int k = 5; k <= 7; k++) begin
            step();
            check("t3_data", 64'(axis_if.tdata), 64'(mul_pow(k, 45)));
        end
        step();
        check("t3_done", 64'(done), 64'd1);
        check("t3_wrap", 64'(period_wrap), 64'd1);
        check("t3_tvalid", 64'(axis_if.tvalid), 64'd0);
        check("t3_running", 64'(running), 64'd0);
        step();
        check("t3_done_pulse", 64'(done), 64'd0);

        // Frequency change deferred to the boundary
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        cfg_freq = mul_pow(1, 46);
        for (int k = 2; k <= 7; k++) begin
            step();
            check("t4_old", 64'(axis_if.tdata), 64'(mul_pow(k, 45)));
        end
        step();
        check("t4_wrap", 64'(axis_if.tdata), 64'd0);
        for (int k = 1; k <= 3; k++) begin
            step();
            check("t4_new", 64'(axis_if.tdata), 64'(mul_pow(k, 46)));
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t4_abort_valid", 64'(axis_if.tvalid), 64'd0);
        check("t4_abort_done", 64'(done), 64'd0);

        // Offset applied to data, wrap only from the accumulator
        cfg_offset = mul_pow(1, 47); cfg_freq = mul_pow(1, 46); start = 1'b1;
        step();
        start = 1'b0;
        check("t5_first", 64'(axis_if.tdata), 64'(mul_pow(1, 47)));
        for (int k = 1; k <= 4; k++) begin
            step();
            check("t5_data", 64'(axis_if.tdata), 64'(mul_pow(2 + k, 46)));
            check("t5_wrap", 64'(period_wrap), 64'(k == 4));
        end
        abort = 1'b1;
        step();
        abort = 1'b0;

        // Period counter, restart and reset mid-run
        cfg_offset = '0; cfg_freq = mul_pow(1, 47); start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 6; k++) step();
`ifdef PHASE_GEN_PERIOD_COUNTER_EN
        check("t6_count3", 64'(period_count), 64'd3);
`endif
        abort = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        check("t6_restart_count", 64'(period_count), 64'd0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_reset_valid", 64'(axis_if.tvalid), 64'd0);
        check("t6_reset_done", 64'(done), 64'd0);

        // Random control, configuration and backpressure
        for (int c = 0; c < 3000; c++) begin
            reset          = ($urandom_range(0, 199) == 0);
            start          = ($urandom_range(0, 9) == 0);
            stop           = ($urandom_range(0, 29) == 0);
            abort          = ($urandom_range(0, 49) == 0);
            axis_if.tready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 19) == 0)
                    cfg_freq = '0;
                else
                    cfg_freq = (PW'($urandom_range(1, 8)) << 44) | PW'($urandom_range(0, 65535));
                cfg_offset = {16'($urandom), 32'($urandom)};
            end
            step();
        end
        reset = 1'b0; start = 1'b0; stop = 1'b0; abort = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
